// File: rtl/meter_timer_pkg.sv
// Shared state encodings and parameter defaults for the parking meter timer.
// Also used by the display block.
package meter_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PAID    = 2'b01,
      ST_EXPIRED = 2'b10,
      ST_ILLEGAL = 2'b11
   } meter_state_t;

   localparam int DEF_DEB_CYCLES = 1000000;
   localparam int DEF_MAX_TIME   = 9999;
   localparam int DEF_COIN_A     = 60;
   localparam int DEF_COIN_B     = 300;

endpackage

// File: rtl/meter_timer_parked_debounce.sv
// Two-flop synchronizer plus debouncer for the asynchronous parked level.
// stable follows raw after DEB_CYCLES consecutive differing synchronized cycles; no backpressure.
module parked_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable
);

   localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any cycle where the synchronized level agrees with stable restarts the count.
         if (sync2 != stable) begin
            if (cnt == CW'(DEB_CYCLES - 1)) begin
               stable <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/meter_timer.sv
// Parking meter: coin credit, 1 Hz countdown and occupancy FSM; coin/tick visible one edge later.
// No backpressure: every coin and tick pulse is consumed in the cycle it arrives.
module meter_timer
   import meter_timer_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int MAX_TIME   = DEF_MAX_TIME,
   parameter int COIN_A     = DEF_COIN_A,
   parameter int COIN_B     = DEF_COIN_B
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        parked,
   input  logic        tick_1hz,
   input  logic        coin_a,
   input  logic        coin_b,
   output logic [13:0] time_left,
   output logic [1:0]  state,
   output logic        occupied,
   output logic        expired,
   output logic        blink
);

   meter_state_t state_q;
   meter_state_t st_next;
   logic [13:0]  tl_next;
   logic         blink_next;
   logic         dec;
   logic [15:0]  credit;
   logic [15:0]  sum;
   logic [15:0]  sat;

   parked_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (parked),
      .stable (occupied)
   );

   // Arithmetic is carried at 16 bits so the pre-saturation sum cannot wrap.
   always_comb begin
      dec    = (state_q == ST_PAID) && tick_1hz && (time_left != 14'd0);
      credit = (coin_a ? 16'(COIN_A) : 16'd0) + (coin_b ? 16'(COIN_B) : 16'd0);
      sum    = {2'b00, time_left} - {15'd0, dec} + credit;
      sat    = (sum > 16'(MAX_TIME)) ? 16'(MAX_TIME) : sum;
   end

   always_comb begin
      st_next = state_q;
      tl_next = sat[13:0];
      case (state_q)
         ST_IDLE: begin
            // Level rather than edge, so an occupied car is picked up even after illegal-state recovery.
            if (occupied)
               st_next = (sat != 16'd0) ? ST_PAID : ST_EXPIRED;
         end
         ST_PAID: begin
            if (!occupied) begin
               st_next = ST_IDLE;
               tl_next = 14'd0;
            end else if (dec && sat == 16'd0) begin
               st_next = ST_EXPIRED;
            end
         end
         ST_EXPIRED: begin
            if (!occupied) begin
               st_next = ST_IDLE;
               tl_next = 14'd0;
            end else if (sat != 16'd0) begin
               st_next = ST_PAID;
            end
         end
         default: begin
            st_next = ST_IDLE;
            tl_next = 14'd0;
         end
      endcase
   end

   always_comb begin
      blink_next = 1'b0;
      if (st_next == ST_EXPIRED)
         blink_next = (state_q == ST_EXPIRED && tick_1hz) ? ~blink : blink;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         time_left <= 14'd0;
         expired   <= 1'b0;
         blink     <= 1'b0;
      end else begin
         state_q   <= st_next;
         time_left <= tl_next;
         expired   <= (st_next == ST_EXPIRED);
         blink     <= blink_next;
      end
   end

   assign state = state_q;

endmodule
